// File: rtl/diff_scan_pkg.sv
// Shared encodings and sizing for the one-hot diff scanner.
// The state values are fixed so that they read the same in waveforms and in any decode logic.
package diff_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    SCAN = 2'b01,
    DONE = 2'b10
  } state_t;

  localparam int WIDTH_C  = 32;
  localparam int CHUNK_C  = 4;
  localparam int IDX_W_C  = 5;
  localparam int NCHUNK_C = WIDTH_C / CHUNK_C;

endpackage

// File: rtl/diff_scan_if.sv
// Request/result bundle between the diff unit's consumer and the scanner.
// The master side issues start/vec_in; the slave side returns busy/done and the result fields.
interface diff_scan_if;
  import diff_pkg::*;

  logic                 start;
  logic [WIDTH_C-1:0]   vec_in;
  logic                 busy;
  logic                 done;
  logic [IDX_W_C-1:0]   idx;
  logic                 zero;
  logic                 multi;

  modport master (output start, vec_in, input busy, done, idx, zero, multi);
  modport slave  (input start, vec_in, output busy, done, idx, zero, multi);
endinterface

// File: rtl/diff_scan_chunk_prio_enc.sv
// Lowest-set-bit encoder for one scan chunk; purely combinational, zero latency.
// There is no handshake: the outputs follow the chunk input directly.
module chunk_prio_enc #(
  parameter int CHUNK = 4,
  parameter int LW    = (CHUNK > 1) ? $clog2(CHUNK) : 1
) (
  input  logic [CHUNK-1:0] chunk_i,
  output logic             any_set_o,
  output logic [LW-1:0]    lo_idx_o,
  output logic             more_than_one_o
);

  assign any_set_o = |chunk_i;
  // Clearing the lowest set bit leaves something only if two or more bits were set.
  assign more_than_one_o = |(chunk_i & (chunk_i - 1'b1));

  always_comb begin
    lo_idx_o = '0;
    for (int i = CHUNK - 1; i >= 0; i--) begin
      if (chunk_i[i]) lo_idx_o = LW'(i);
    end
  end

endmodule

// File: rtl/diff_scan.sv
// One-hot to binary index with zero/multi-hot flags; scans CHUNK bits per cycle, done WIDTH/CHUNK+1 cycles after start.
// start is ignored while busy (no queueing); a held start is re-accepted in the first IDLE cycle.
module diff_scan
  import diff_pkg::*;
#(
  parameter int WIDTH = WIDTH_C,
  parameter int CHUNK = CHUNK_C,
  parameter int IDX_W = IDX_W_C
) (
  input  logic        clk,
  input  logic        rst,
  diff_scan_if.slave  bus
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int CNT_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam int LW     = (CHUNK > 1) ? $clog2(CHUNK) : 1;

  state_t             state_q;
  logic [WIDTH-1:0]   vec_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               found_q, found_d;
  logic               macc_q, macc_d;
  logic [IDX_W-1:0]   iacc_q, iacc_d;
  logic               busy_q, done_q, zero_q, multi_q;
  logic [IDX_W-1:0]   idx_q;

  logic [CHUNK-1:0]   cur_chunk;
  logic               enc_any, enc_more;
  logic [LW-1:0]      enc_lo;

  assign cur_chunk = vec_q[cnt_q*CHUNK +: CHUNK];

  chunk_prio_enc #(.CHUNK(CHUNK), .LW(LW)) u_enc (
    .chunk_i         (cur_chunk),
    .any_set_o       (enc_any),
    .lo_idx_o        (enc_lo),
    .more_than_one_o (enc_more)
  );

  // Accumulators as they stand after folding in the current chunk.
  always_comb begin
    found_d = found_q;
    macc_d  = macc_q;
    iacc_d  = iacc_q;
    if (enc_any && !found_q) begin
      iacc_d  = IDX_W'(IDX_W'(cnt_q) * IDX_W'(CHUNK)) + IDX_W'(enc_lo);
      found_d = 1'b1;
    end
    if (enc_more || (enc_any && found_q)) macc_d = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      vec_q   <= '0;
      cnt_q   <= '0;
      found_q <= 1'b0;
      macc_q  <= 1'b0;
      iacc_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      idx_q   <= '0;
      zero_q  <= 1'b0;
      multi_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            vec_q   <= bus.vec_in;
            found_q <= 1'b0;
            macc_q  <= 1'b0;
            iacc_q  <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= SCAN;
          end
        end
        SCAN: begin
          found_q <= found_d;
          macc_q  <= macc_d;
          iacc_q  <= iacc_d;
          cnt_q   <= cnt_q + 1'b1;
          if (cnt_q == CNT_W'(NCHUNK - 1)) begin
            state_q <= DONE;
            done_q  <= 1'b1;
            idx_q   <= found_d ? iacc_d : '0;
            zero_q  <= !found_d;
            multi_q <= macc_d;
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy  = busy_q;
  assign bus.done  = done_q;
  assign bus.idx   = idx_q;
  assign bus.zero  = zero_q;
  assign bus.multi = multi_q;

endmodule

// File: doc/diff_scan.md
Name: diff_scan

Overview:
- Sequential consumer of the diff unit's 32-bit one-hot output.
- Converts the one-hot vector into a binary bit index for register writeback.
- Scans CHUNK bits per cycle to keep area small.
- Flags two input errors: an all-zero vector (operands equal) and a vector that is not one-hot.

Parameters:
- WIDTH, 32: input vector width; must be a multiple of CHUNK.
- CHUNK, 4: bits examined per scan cycle.
- IDX_W, 5: index width, equal to clog2(WIDTH).

Ports:
- clk, input, 1: system clock; all state updates on rising edge.
- rst, input, 1: asynchronous, active-high reset.
- start, input, 1: request; sampled only in IDLE.
- vec_in, input, WIDTH: diff output vector; captured on an accepted start.
- busy, output, 1: high in SCAN and DONE.
- done, output, 1: high for exactly one cycle, in DONE state.
- idx, output, IDX_W: index of the lowest set bit of the captured vector.
- zero, output, 1: captured vector was all zeros.
- multi, output, 1: captured vector had more than one bit set.

Behaviour:
- Reset: rst is asynchronous and active-high. It forces state=IDLE, busy=0, done=0, idx=0, zero=0, multi=0, chunk counter=0, captured vector=0. Reset mid-SCAN aborts with no done pulse.
- States:
  - IDLE: start=1 at an edge latches vec_in into a shadow register, clears the working flags (found, multi accumulator, idx accumulator), sets cnt=0, and goes to SCAN.
  - SCAN: each edge processes chunk cnt, i.e. bits [cnt*CHUNK +: CHUNK], then increments cnt. On the edge processing chunk WIDTH/CHUNK-1, the state goes to DONE and the outputs register.
  - DONE: done=1 for one cycle, then IDLE on the next edge.
- Latency:
  - Fixed; there is no early exit, so the bench can check exact cycle counts.
  - Start accepted at edge T means chunks are processed at edges T+1..T+WIDTH/CHUNK. With defaults that is T+1..T+8.
  - done is high during the cycle after edge T+8.
  - Start-to-done is 9 cycles with defaults.
- Per-chunk rule:
  - If the chunk has a set bit and found=0: idx_acc = cnt*CHUNK + lowest local set position; found=1.
  - If the chunk has 2+ set bits, or has any set bit while found=1: multi_acc=1.
- Result at DONE:
  - idx=idx_acc, or 0 if nothing was found.
  - zero = !found.
  - multi = multi_acc.
  - zero and multi are never both 1.
- Outputs hold from DONE until the next accepted start. At the accept edge idx, zero and multi keep their old values; they change only at the DONE entry edge.
- start while busy (SCAN or DONE) is ignored, with no queueing. A start held continuously is re-accepted in the first IDLE cycle after DONE, so back-to-back issue runs one transaction every 10 cycles.
- vec_in changing during SCAN has no effect; only the shadow register is scanned.
- Arithmetic: index addition is unsigned IDX_W bits and cannot overflow since the maximum is WIDTH-1. cnt is a clog2(WIDTH/CHUNK)-bit counter that wraps to 0 after the last chunk.

Decomposition:
- Shared package diff_pkg holds:
  - state encoding IDLE=2'b00, SCAN=2'b01, DONE=2'b10;
  - constants WIDTH_C=32, CHUNK_C=4, IDX_W_C=5, NCHUNK_C=WIDTH_C/CHUNK_C.
- One sub-module, chunk_prio_enc. It is combinational: a CHUNK-bit input produces any_set, lowest local index, and more_than_one. Instantiate it once on the current chunk slice.
- The FSM, counter, shadow register and accumulators live in diff_scan.

Test Plan:
- Single bit:
  - vec_in=32'h0000_0001, start at T -> done in the cycle after T+8; idx=0, zero=0, multi=0.
  - vec_in=32'h8000_0000 -> idx=31.
- Mid-chunk bit: vec_in=32'h0000_0400 (bit 10, chunk 2) -> idx=10, zero=0, multi=0.
- Zero vector: vec_in=0 -> zero=1, idx=0, multi=0, done still at the 9-cycle latency.
- Multi-hot:
  - vec_in=32'h0001_0010 -> idx=4, multi=1.
  - vec_in=32'h0000_000C (same chunk) -> idx=2, multi=1.
- Handshake:
  - start pulsed at T+3 while busy -> ignored, exactly one done pulse, vec_in changes during SCAN ignored.
  - start held high -> done pulses 10 cycles apart.
- Reset: assert rst asynchronously mid-SCAN (between edges) -> outputs 0 immediately, no done pulse. After release, a new start with vec_in=32'h0000_0100 -> idx=8.
